// File: rtl/cache_refill_ctrl_if.sv
// Bundle of CPU, cache and memory signals around the refill controller.
// master = controller side, slave = CPU/cache/memory side.
interface cache_refill_ctrl_if #(
  parameter int TAG_W    = 20,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 4,
  parameter int DATA_W   = 32
);
  logic                cpu_req;
  logic [31:0]         cpu_addr;
  logic                cpu_ready;
  logic                cpu_done;
  logic [DATA_W-1:0]   cpu_rdata;
  logic                flush;

  logic [31:0]         cache_addr;
  logic                cache_hit;
  logic [DATA_W-1:0]   cache_rdata;

  logic                fill_we;
  logic [INDEX_W-1:0]  fill_index;
  logic [OFFSET_W-1:0] fill_offset;
  logic [DATA_W-1:0]   fill_data;
  logic                tag_we;
  logic [TAG_W-1:0]    tag_data;

  logic                mem_req;
  logic [31:0]         mem_addr;
  logic                mem_ack;
  logic [DATA_W-1:0]   mem_rdata;

  logic [15:0]         hit_count;
  logic [15:0]         miss_count;

  modport master (
    input  cpu_req, cpu_addr, flush, cache_hit, cache_rdata, mem_ack, mem_rdata,
    output cpu_ready, cpu_done, cpu_rdata, cache_addr,
    output fill_we, fill_index, fill_offset, fill_data, tag_we, tag_data,
    output mem_req, mem_addr, hit_count, miss_count
  );

  modport slave (
    output cpu_req, cpu_addr, flush, cache_hit, cache_rdata, mem_ack, mem_rdata,
    input  cpu_ready, cpu_done, cpu_rdata, cache_addr,
    input  fill_we, fill_index, fill_offset, fill_data, tag_we, tag_data,
    input  mem_req, mem_addr, hit_count, miss_count
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Miss-handling controller for a direct-mapped cache: issues lookups, owns the
// per-line valid bits, refills a whole line word by word from memory on a miss,
// then writes the tag and returns the requested word to the CPU.
//
// state  | meaning
// IDLE   | ready for a CPU read; flush clears all valid bits here
// LOOKUP | lookup address presented to the cache
// CHECK  | registered tag-match qualified with the valid bit
// REFILL | one memory word per mem_ack, written straight into the data array
// TAGWR  | tag written, line marked valid
// RESP   | cpu_done pulse with the captured word
module cache_refill_ctrl #(
  parameter int TAG_W    = 20,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 4,
  parameter int DATA_W   = 32
) (
  input  logic clk,
  input  logic reset,
  cache_refill_ctrl_if.master bus
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    CHECK  = 3'd2,
    REFILL = 3'd3,
    TAGWR  = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         addr_q;
  logic [LINES-1:0]    valid_q;
  logic [OFFSET_W-1:0] cnt_q;
  logic [DATA_W-1:0]   resp_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [15:0]         hit_count_q;
  logic [15:0]         miss_count_q;

  logic [TAG_W-1:0]    addr_tag;
  logic [INDEX_W-1:0]  addr_index;
  logic [OFFSET_W-1:0] addr_offset;
  logic                hit;
  logic                last_word;

  assign addr_tag    = addr_q[31 -: TAG_W];
  assign addr_index  = addr_q[OFFSET_W +: INDEX_W];
  assign addr_offset = addr_q[OFFSET_W-1:0];
  // A tag match on a line we never filled (or flushed) must still miss.
  assign hit         = bus.cache_hit & valid_q[addr_index];
  assign last_word   = (cnt_q == {OFFSET_W{1'b1}});

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush in IDLE takes priority over a pending request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!bus.flush && bus.cpu_req) state_d = LOOKUP;
      LOOKUP:  state_d = CHECK;
      CHECK:   state_d = hit ? RESP : REFILL;
      REFILL:  if (bus.mem_ack && last_word) state_d = TAGWR;
      TAGWR:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address latch, valid bits, refill counter, captured data and statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q       <= '0;
      valid_q      <= '0;
      cnt_q        <= '0;
      resp_q       <= '0;
      rdata_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.flush)        valid_q <= '0;
          else if (bus.cpu_req) addr_q  <= bus.cpu_addr;
        end
        CHECK: begin
          if (hit) begin
            rdata_q <= bus.cache_rdata;
            if (hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
          end else begin
            // Line stays invalid until every word and the tag are rewritten.
            valid_q[addr_index] <= 1'b0;
            cnt_q               <= '0;
            if (miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
          end
        end
        REFILL: begin
          if (bus.mem_ack) begin
            if (cnt_q == addr_offset) resp_q <= bus.mem_rdata;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        TAGWR: begin
          valid_q[addr_index] <= 1'b1;
          rdata_q             <= resp_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.cpu_ready   = (state_q == IDLE);
  assign bus.cpu_done    = (state_q == RESP);
  assign bus.cpu_rdata   = rdata_q;
  assign bus.cache_addr  = ((state_q == LOOKUP) || (state_q == CHECK)) ? addr_q : 32'd0;
  assign bus.fill_we     = (state_q == REFILL) & bus.mem_ack;
  assign bus.fill_index  = addr_index;
  assign bus.fill_offset = cnt_q;
  assign bus.fill_data   = bus.mem_rdata;
  assign bus.tag_we      = (state_q == TAGWR);
  assign bus.tag_data    = addr_tag;
  assign bus.mem_req     = (state_q == REFILL);
  assign bus.mem_addr    = {addr_q[31:OFFSET_W], cnt_q};
  assign bus.hit_count   = hit_count_q;
  assign bus.miss_count  = miss_count_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: directed scenarios followed by randomized reads,
// checked against a transaction-level model (valid bits, counters, latency).
module tb_cache_refill_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_refill_ctrl_if bus ();

  cache_refill_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  bit [255:0]  mvalid;
  int          exp_hits;
  int          exp_misses;
  logic [31:0] last_rdata;
  int          last_lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  // One CPU read. stall_word/stall_len: drop mem_ack before that word;
  // rnd_stall: random ack gaps; rst_word: assert reset when that word is due.
  task automatic do_read(input logic [31:0] addr, input logic hit_in,
                         input logic [31:0] hit_data, input int stall_word,
                         input int stall_len, input bit rnd_stall, input int rst_word);
    int          idx = int'(addr[11:4]);
    int          word = 0;
    int          stalls = 0;
    int          tagw = 0;
    int          cyc = 0;
    bit          done = 0;
    logic        exp_hit;
    logic [31:0] exp_data;
    logic [31:0] waddr;
    @(posedge clk); #2;
    chk("ready_idle", bus.cpu_ready, 1'b1);
    chk("rdata_hold", bus.cpu_rdata, last_rdata);
    exp_hit  = hit_in && mvalid[idx];
    exp_data = exp_hit ? hit_data : mem_word(addr);
    bus.cpu_req     = 1'b1;
    bus.cpu_addr    = addr;
    bus.cache_hit   = hit_in;
    bus.cache_rdata = hit_data;
    while (!done) begin
      @(posedge clk); #1;
      cyc++;
      bus.mem_ack = 1'b0;
      if (cyc > 200) begin
        checks++;
        errors++;
        $error("FAIL timeout observed=%0d cycles expected cpu_done", cyc);
        break;
      end
      if (exp_hit) chk("hit_no_mem", bus.mem_req, 1'b0);
      if (cyc == 1 || cyc == 2) chk("cache_addr", bus.cache_addr, addr);
      waddr = {addr[31:4], word[3:0]};
      if (bus.mem_req) begin
        chk("mem_addr", bus.mem_addr, waddr);
        if (word == rst_word) begin
          reset = 1'b1;
          bus.mem_ack = 1'b1;
          #1;
          chk("rst_mem_req", bus.mem_req, 1'b0);
          chk("rst_fill_we", bus.fill_we, 1'b0);
          chk("rst_ready", bus.cpu_ready, 1'b1);
          chk("rst_hits", bus.hit_count, 16'd0);
          chk("rst_misses", bus.miss_count, 16'd0);
          mvalid      = '0;
          exp_hits    = 0;
          exp_misses  = 0;
          last_rdata  = '0;
          bus.cpu_req = 1'b0;
          bus.mem_ack = 1'b0;
          return;
        end
        if ((word == stall_word && stalls < stall_len) ||
            (rnd_stall && $urandom_range(0, 3) == 0))
          stalls++;
        else
          bus.mem_ack = 1'b1;
        bus.mem_rdata = mem_word(waddr);
      end
      #1;
      if (bus.mem_req) chk("fill_we_ack", bus.fill_we, bus.mem_ack);
      else             chk("fill_we_idle", bus.fill_we, 1'b0);
      if (bus.fill_we) begin
        chk("fill_offset", bus.fill_offset, word[3:0]);
        chk("fill_data", bus.fill_data, mem_word(waddr));
        chk("fill_index", bus.fill_index, addr[11:4]);
        word++;
      end
      if (bus.tag_we) begin
        chk("tag_after_fills", word, 16);
        chk("tag_data", bus.tag_data, addr[31:12]);
        chk("tag_index", bus.fill_index, addr[11:4]);
        tagw++;
      end
      if (bus.cpu_done) begin
        last_lat = cyc;
        chk("latency", cyc, exp_hit ? 3 : 20 + stalls);
        chk("rdata", bus.cpu_rdata, exp_data);
        chk("tag_we_count", tagw, exp_hit ? 0 : 1);
        if (exp_hit) exp_hits = sat_inc(exp_hits);
        else begin
          exp_misses  = sat_inc(exp_misses);
          mvalid[idx] = 1'b1;
        end
        chk("hit_count", bus.hit_count, exp_hits[15:0]);
        chk("miss_count", bus.miss_count, exp_misses[15:0]);
        last_rdata = exp_data;
        done = 1;
      end
    end
    bus.cpu_req = 1'b0;
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    reset = 1'b1;
    bus.cpu_req = 0; bus.cpu_addr = 0; bus.flush = 0; bus.cache_hit = 0;
    bus.cache_rdata = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
    mvalid = '0; exp_hits = 0; exp_misses = 0; last_rdata = '0; last_lat = 0;

    // Reset values.
    #7;
    chk("reset_ready", bus.cpu_ready, 1'b1);
    chk("reset_done", bus.cpu_done, 1'b0);
    chk("reset_rdata", bus.cpu_rdata, 32'd0);
    chk("reset_mem_req", bus.mem_req, 1'b0);
    chk("reset_fill_we", bus.fill_we, 1'b0);
    chk("reset_tag_we", bus.tag_we, 1'b0);
    chk("reset_cache_addr", bus.cache_addr, 32'd0);
    chk("reset_hits", bus.hit_count, 16'd0);
    chk("reset_misses", bus.miss_count, 16'd0);
    @(negedge clk); reset = 1'b0;

    // Cold miss on 0x1234: full refill, word 4 returned.
    do_read(32'h0000_1234, 1'b0, 32'h0, -1, 0, 0, -1);
    // Same address now hits.
    do_read(32'h0000_1234, 1'b1, 32'hDEAD_BEEF, -1, 0, 0, -1);
    // Miss with a three-cycle ack gap before word 7.
    do_read(32'h0000_5678, 1'b0, 32'h0, 7, 3, 0, -1);
    chk("stall_latency", last_lat, 23);

    // flush together with cpu_req: flush wins and the line turns invalid.
    @(posedge clk); #2;
    bus.flush = 1'b1; bus.cpu_req = 1'b1; bus.cpu_addr = 32'h0000_1234;
    @(posedge clk); #2;
    chk("flush_stays_idle", bus.cpu_ready, 1'b1);
    chk("flush_no_lookup", bus.cache_addr, 32'd0);
    bus.flush = 1'b0; bus.cpu_req = 1'b0;
    mvalid = '0;
    do_read(32'h0000_1234, 1'b1, 32'h1111_2222, -1, 0, 0, -1);

    // Reset while word 9 is due; the line must miss afterwards.
    do_read(32'h0000_9AB4, 1'b0, 32'h0, -1, 0, 0, 9);
    @(negedge clk); reset = 1'b0;
    do_read(32'h0000_9AB4, 1'b1, 32'h3333_4444, -1, 0, 0, -1);

    // Hit counter saturation: preload near the top to keep the run short.
    force dut.hit_count_q = 16'hFFFC;
    #1;
    release dut.hit_count_q;
    exp_hits = 32'hFFFC;
    for (int i = 0; i < 5; i++)
      do_read(32'h0000_9AB0 + i, 1'b1, $urandom, -1, 0, 0, -1);
    chk("hit_saturated", bus.hit_count, 16'hFFFF);

    // Randomized reads over a small tag/index space with random ack gaps.
    for (int i = 0; i < 30; i++) begin
      a = {18'd0, 2'($urandom_range(0, 3)), 6'd0, 2'($urandom_range(0, 3)), 4'($urandom)};
      do_read(a, 1'($urandom_range(0, 1)), $urandom, -1, 0, 1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
